// File: rtl/keystream_xor_engine.sv
// keystream_xor_engine
// Consumer end of the chaotic state stream: drops the first DISCARD state
// triples, folds every later triple into a 32-bit keystream word, buffers the
// words in a DEPTH-entry FIFO and XORs them onto a valid/ready data stream.
// Encryption and decryption are the same operation.
// Optional feature: define KSX_WORD_COUNT_EN to build the dout transfer counter
// (word_count); otherwise word_count is tied to zero.
module keystream_xor_engine #(
    parameter int DEPTH   = 4,
    parameter int DISCARD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] xp,
    input  logic [31:0] xs,
    input  logic [31:0] xl,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] din,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] dout,
    output logic [31:0] word_count
);

    localparam int          PW        = $clog2(DEPTH);
    localparam logic [15:0] DISCARD_W = 16'(DISCARD);
    localparam logic [PW:0] PTR_ONE   = (PW+1)'(1);
    localparam logic [PW:0] PTR_MSB   = {1'b1, {PW{1'b0}}};

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] warm_cnt;
    logic [31:0] mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        st_acc;
    logic        push;
    logic        load;

    // Keystream fold: xp ^ rotl(xs,8) ^ rotl(xl,16), pure bitwise mixing.
    function automatic logic [31:0] fold(input logic [31:0] p,
                                         input logic [31:0] s,
                                         input logic [31:0] l);
        return p ^ {s[23:0], s[31:24]} ^ {l[15:0], l[31:16]};
    endfunction

    // Handshake decode; every ready depends only on registered state and the
    // current din_valid/dout_ready, never on the data buses.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = ((wr_ptr ^ rd_ptr) == PTR_MSB);
        st_ready   = (state == WARMUP) ? 1'b1 : !fifo_full;
        st_acc     = st_valid && st_ready;
        push       = st_acc && (state == RUN);
        load       = din_valid && !fifo_empty && (!dout_valid || dout_ready);
        din_ready  = load;
    end

    // Warm-up FSM: count discarded triples, then stay in RUN until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (DISCARD == 0) ? RUN : WARMUP;
            warm_cnt <= 16'd0;
        end else if (state == WARMUP && st_acc) begin
            warm_cnt <= warm_cnt + 16'd1;
            if (warm_cnt + 16'd1 == DISCARD_W) begin
                state <= RUN;
            end
        end
    end

    // FIFO pointers: one extra wrap bit separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= fold(xp, xs, xl);
        end
    end

    // Single-entry output register; holds steady while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_valid <= 1'b0;
            dout       <= 32'd0;
        end else if (load) begin
            dout_valid <= 1'b1;
            dout       <= din ^ mem[rd_ptr[PW-1:0]];
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

`ifdef KSX_WORD_COUNT_EN
    // Count completed output transfers, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= 32'd0;
        end else if (dout_valid && dout_ready) begin
            word_count <= word_count + 32'd1;
        end
    end
`else
    assign word_count = 32'd0;
`endif

endmodule

// File: doc/keystream_xor_engine.md
# keystream_xor_engine

Consumer end of the chaotic internal-state stream. It accepts successive (Xp, Xs, Xl) state triples from the coupled-map state generator and discards the first DISCARD triples as the chaotic transient. Each later triple is folded into one 32-bit keystream word and buffered in a small FIFO. Buffered words are XORed with a valid/ready data stream, so the same block performs encryption or decryption.

## Interface
- DEPTH, 4: keystream FIFO depth in words; power of two, ≥2.
- DISCARD, 16: number of state triples dropped after reset before keystream generation starts; 0 allowed.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- st_valid  in  1  state triple present on xp/xs/xl.
- st_ready  out  1  block accepts the triple this cycle.
- xp, xs, xl  in  32 each  state words Xpn, Xsn, Xln from the generator.
- din_valid  in  1  plaintext/ciphertext word present.
- din_ready  out  1  block consumes din this cycle.
- din  in  32  input data word.
- dout_valid  out  1  output word valid.
- dout_ready  in  1  downstream accepts dout.
- dout  out  32  din XOR keystream.
- word_count  out  32  count of completed dout transfers (see Configuration).

## Operation
- Keystream fold: K = xp ^ rotl(xs,8) ^ rotl(xl,16), 32-bit, no carries.
- The FSM has two states.
  - WARMUP: st_ready=1. Each st_valid&&st_ready increments the 16-bit warm counter. When an accepted triple brings the counter to DISCARD, go to RUN. That triple is discarded.
  - RUN: st_ready = !fifo_full. An accepted triple pushes K into the FIFO. The FSM stays in RUN until reset.
  - If DISCARD=0, reset enters RUN directly and WARMUP is never visited.
- FIFO holds DEPTH entries and uses log2(DEPTH)+1-bit read/write pointers that wrap modulo 2·DEPTH.
  - Full when the pointers differ only in the MSB.
  - Empty when the pointers are equal.
- Output register is a single entry.
  - load = din_valid && !fifo_empty && (!dout_valid || dout_ready).
  - din_ready = load.
  - On load: dout <= din ^ fifo_head, dout_valid <= 1, FIFO pops.
  - On dout_ready && !load: dout_valid <= 0.
- Push and pop in the same cycle are allowed when the FIFO is non-empty and not full; occupancy is unchanged.
- A push into a full FIFO never occurs because st_ready is low. No pass-through from an empty FIFO: a word pushed in cycle n can be popped no earlier than cycle n+1.
- A stalled output (dout_valid && !dout_ready) holds dout stable and deasserts din_ready.
- Reset at any time flushes the FIFO, clears the warm counter and word_count, and returns to WARMUP (or RUN when DISCARD=0). Triples and data words in flight are dropped, not completed.

## Timing
- Values after reset: st_ready=1, din_ready=0, dout_valid=0, dout=0, word_count=0.
- Triple-to-keystream latency: a triple accepted at edge n is poppable in the cycle after edge n.
- din-to-dout latency: 1 cycle. din accepted at edge n appears as dout_valid=1 after edge n.
- Throughput: 1 word/cycle once the FIFO is non-empty and dout_ready is held at 1.
- st_ready, din_ready and dout_valid depend only on registered state and the current din_valid/dout_ready. There are no combinational paths from xp/xs/xl/din to any ready signal.

## Configuration
- KSX_WORD_COUNT_EN defined:
  - word_count increments on every dout_valid && dout_ready transfer.
  - It wraps from 0xFFFFFFFF to 0.
  - It is cleared by reset.
- KSX_WORD_COUNT_EN undefined:
  - The counter is not built.
  - word_count is tied to 32'd0.
  - All other behaviour is identical.

## Test plan
- Warm-up discard: DISCARD=2. Send 3 triples, the third being xp=0x11111111, xs=0x000000FF, xl=0x0000FF00. Then send din=0xEE11EE11. Required: dout=0x00000000 one cycle later, and only one FIFO entry is ever written.
- FIFO full: DEPTH=4, DISCARD=0, din_valid=0. Stream 6 triples. Required: st_ready drops after the 4th accept and the 5th and 6th are held; one din transfer then re-raises st_ready on the next cycle.
- Empty stall: FIFO empty, din_valid=1, din=0xA5A5A5A5. Required: din_ready=0 and dout_valid=0 until the first keystream push, then dout=0xA5A5A5A5^K one cycle after that push.
- Backpressure: dout_ready=0 for 5 cycles with a loaded output. Required: dout and dout_valid are stable, din_ready=0, and no FIFO pop occurs. Release gives exactly one transfer per cycle with no lost or duplicated words.
- Encrypt/decrypt round trip: two instances fed identical triples (DISCARD=16) and chained. Feeding 100 random din words into the first must reproduce the input at the second's dout. With KSX_WORD_COUNT_EN defined, word_count=100.
- Mid-run reset: assert reset for 1 cycle while the FIFO holds 3 words and dout_valid=1. Required: all outputs return to their reset values, and the next 16 triples are discarded again.
